translated_mem_stage: RTL and testbench

- Downstream consumer of the handle translation stage.
- Takes its translated op/address/data outputs, queues them in an in-order request FIFO, and services them against an internal word-addressed RAM.
- Returns read data with fixed latency and flags illegal ops and out-of-range addresses.
- Gives upstream a stall signal so bursts of requests are never lost.

---
 rtl/translated_mem_stage_if.sv | 23 ++
 rtl/translated_mem_stage.sv | 109 ++++++++++
 tb/tb_translated_mem_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/translated_mem_stage_if.sv
// rtl/translated_mem_stage_if.sv - request/response bundle between translation stage and memory stage
interface translated_mem_stage_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [2:0]            i_op;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [ADDR_WIDTH-1:0] i_data;
  logic                  o_stall;
  logic [ADDR_WIDTH-1:0] o_rdata;
  logic                  o_rvalid;
  logic                  o_error;
  logic                  o_busy;

  modport master (
    output i_op, i_address, i_data,
    input  o_stall, o_rdata, o_rvalid, o_error, o_busy
  );

  modport slave (
    input  i_op, i_address, i_data,
    output o_stall, o_rdata, o_rvalid, o_error, o_busy
  );
endinterface

// File: rtl/translated_mem_stage.sv
// rtl/translated_mem_stage.sv - in-order request FIFO servicing a word-addressed RAM
module translated_mem_stage #(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_AW     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  translated_mem_stage_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] mem_q       [2**MEM_AW];
  logic                  fifo_wr_q   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  s1_rd_q, s1_rd_d;
  logic                  s1_err_q, s1_err_d;
  logic [ADDR_WIDTH-1:0] s1_word_q, s1_word_d;
  logic                  rvalid_q, rvalid_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] rdata_q, rdata_d;

  logic                  stall;
  logic                  push;
  logic                  pop;
  logic                  illegal;
  logic                  head_wr;
  logic                  head_in_range;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [ADDR_WIDTH-1:0] head_data;
  logic [MEM_AW-1:0]     head_idx;

  assign stall        = (count_q == FULL_COUNT);
  assign bus.o_stall  = stall;
  assign bus.o_rdata  = rdata_q;
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_error  = error_q;
  assign bus.o_busy   = (count_q != '0) || s1_rd_q;

  // Decode the incoming op and look at the FIFO head that is serviced this cycle
  always_comb begin
    push          = ((bus.i_op == 3'd1) || (bus.i_op == 3'd2)) && !stall;
    illegal       = (bus.i_op > 3'd2);
    pop           = (count_q != '0);
    head_wr       = fifo_wr_q[rd_ptr_q];
    head_addr     = fifo_addr_q[rd_ptr_q];
    head_data     = fifo_data_q[rd_ptr_q];
    head_idx      = head_addr[MEM_AW-1:0];
    head_in_range = (head_addr[ADDR_WIDTH-1:MEM_AW] == '0);
  end

  // Next-state: queue bookkeeping, read stage, and registered response outputs
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    s1_rd_d   = pop && !head_wr;
    s1_err_d  = pop && !head_in_range;
    // Out-of-range reads return zero, so force the sampled word here
    s1_word_d = head_in_range ? mem_q[head_idx] : '0;
    rvalid_d  = s1_rd_q;
    rdata_d   = s1_rd_q ? s1_word_q : rdata_q;
    error_d   = illegal || s1_err_q;
  end

  // State register; reset drops queued entries and any read in flight
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s1_rd_q   <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_word_q <= '0;
      rvalid_q  <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s1_rd_q   <= s1_rd_d;
      s1_err_q  <= s1_err_d;
      s1_word_q <= s1_word_d;
      rvalid_q  <= rvalid_d;
      error_q   <= error_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage: FIFO entry capture and in-range RAM writes; contents survive reset
  always_ff @(posedge i_clock) begin
    if (push) begin
      fifo_wr_q[wr_ptr_q]   <= (bus.i_op == 3'd2);
      fifo_addr_q[wr_ptr_q] <= bus.i_address;
      fifo_data_q[wr_ptr_q] <= bus.i_data;
    end
    if (!i_reset && pop && head_wr && head_in_range) begin
      mem_q[head_idx] <= head_data;
    end
  end
endmodule

// File: tb/tb_translated_mem_stage.sv
// tb/tb_translated_mem_stage.sv - randomized self-checking bench for translated_mem_stage
module tb_translated_mem_stage;
  localparam int DEPTH = 4;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } req_t;

  logic clk;
  logic rst;

  translated_mem_stage_if #(.ADDR_WIDTH(16)) bus ();

  translated_mem_stage #(
    .ADDR_WIDTH(16),
    .MEM_AW    (8),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  req_t        q[$];
  logic [15:0] m_mem [256];
  logic [15:0] m_rdata;
  bit          exp_rv  [8];
  logic [15:0] exp_rd  [8];
  bit          exp_err [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the event-schedule model, then compare
  task automatic step(input logic [2:0] op, input logic [15:0] addr,
                      input logic [15:0] data, input bit r);
    req_t e;
    bit   stall_now;
    bit   inr;
    bit   erv, eerr, ebusy;
    int   s0, s1;
    rst           = r;
    bus.i_op      = op;
    bus.i_address = addr;
    bus.i_data    = data;
    @(posedge clk);
    s0 = cyc % 8;
    s1 = (cyc + 1) % 8;
    if (r) begin
      q.delete();
      for (int i = 0; i < 8; i++) begin
        exp_rv[i]  = 1'b0;
        exp_err[i] = 1'b0;
      end
      m_rdata = '0;
    end else begin
      stall_now = (q.size() == DEPTH);
      if (op > 3'd2) exp_err[s0] = 1'b1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        inr = (e.addr < 16'd256);
        if (e.wr) begin
          if (inr) m_mem[e.addr[7:0]] = e.data;
          else     exp_err[s1] = 1'b1;
        end else begin
          exp_rv[s1] = 1'b1;
          exp_rd[s1] = inr ? m_mem[e.addr[7:0]] : 16'h0000;
          if (!inr) exp_err[s1] = 1'b1;
        end
      end
      if ((op == 3'd1 || op == 3'd2) && !stall_now) begin
        e.wr   = (op == 3'd2);
        e.addr = addr;
        e.data = data;
        q.push_back(e);
      end
    end
    erv  = exp_rv[s0];
    eerr = exp_err[s0];
    if (erv) m_rdata = exp_rd[s0];
    ebusy = (q.size() != 0) || exp_rv[s1];
    exp_rv[s0]  = 1'b0;
    exp_err[s0] = 1'b0;
    #1;
    check_eq("rvalid", bus.o_rvalid, erv);
    check_eq("rdata",  bus.o_rdata,  m_rdata);
    check_eq("error",  bus.o_error,  eerr);
    check_eq("stall",  bus.o_stall,  (q.size() == DEPTH));
    check_eq("busy",   bus.o_busy,   ebusy);
    cyc++;
  endtask

  // Present a request and hold it while the model says the queue is full
  task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] data);
    int  guard;
    bit  taken;
    guard = 0;
    taken = 1'b0;
    while (!taken && guard < 16) begin
      taken = (q.size() != DEPTH);
      step(op, addr, data, 1'b0);
      guard++;
    end
    if (!taken) begin
      n_vec++;
      n_err++;
      $display("FAIL hold_bound: request op %0d addr %0h never accepted", op, addr);
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [15:0] addr;
    int          r;
    rst           = 1'b1;
    bus.i_op      = 3'd0;
    bus.i_address = '0;
    bus.i_data    = '0;

    step(3'd0, 16'h0, 16'h0, 1'b1);
    step(3'd0, 16'h0, 16'h0, 1'b1);

    for (int i = 0; i < 256; i++) issue(3'd2, 16'(i), 16'($urandom));

    issue(3'd2, 16'h0005, 16'hBEEF);
    issue(3'd1, 16'h0005, 16'h0);
    issue(3'd2, 16'h0001, 16'h0011);
    issue(3'd2, 16'h0002, 16'h0022);
    issue(3'd2, 16'h0003, 16'h0033);
    issue(3'd1, 16'h0001, 16'h0);
    issue(3'd1, 16'h0002, 16'h0);
    issue(3'd1, 16'h0003, 16'h0);
    for (int i = 0; i < 3; i++) step(3'd0, 16'h0, 16'h0, 1'b0);

    for (int i = 0; i < 8; i++) issue(3'd1, 16'(i), 16'h0);
    for (int i = 0; i < 5; i++) issue(3'd2, 16'(8'h40 + i), 16'(16'h5000 + i));

    step(3'd3, 16'h0010, 16'h0, 1'b0);
    step(3'd0, 16'h0, 16'h0, 1'b0);

    issue(3'd1, 16'h0100, 16'h0);
    issue(3'd2, 16'h0100, 16'h1234);
    issue(3'd1, 16'h0000, 16'h0);
    for (int i = 0; i < 3; i++) step(3'd0, 16'h0, 16'h0, 1'b0);

    issue(3'd1, 16'h0007, 16'h0);
    issue(3'd1, 16'h0008, 16'h0);
    issue(3'd1, 16'h0009, 16'h0);
    step(3'd0, 16'h0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(3'd0, 16'h0, 16'h0, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0)
        addr = {8'($urandom_range(1, 255)), 8'($urandom)};
      else
        addr = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) begin
        step(3'd1, addr, 16'($urandom), 1'b1);
      end else begin
        if (r < 2)       op = 3'd0;
        else if (r < 8)  op = 3'd1;
        else if (r < 14) op = 3'd2;
        else             op = 3'($urandom_range(3, 7));
        if (op == 3'd1 || op == 3'd2) issue(op, addr, 16'($urandom));
        else                          step(op, addr, 16'($urandom), 1'b0);
      end
    end
    for (int i = 0; i < 4; i++) step(3'd0, 16'h0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
